// File: rtl/srlzr_ctrl.sv
// Two-requester round-robin front end for an external PISO shift register.
// A word is loaded on grant and then shifted out one bit per cycle. The next
// word may be loaded on the last bit cycle, so consecutive words have no gap.
module srlzr_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             piso_load,
    output logic [WIDTH-1:0] piso_x,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_sof,
    output logic             ser_src,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_src;
    logic             w_src_nxt;
    logic             r_rr;
    logic             w_rr_nxt;
    logic             w_any;
    logic             w_gnt;
    logic             w_grant_en;
    logic             w_load;
    logic [WIDTH-1:0] w_x;
    logic             w_rdy0;
    logic             w_rdy1;
    logic             w_sv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_src   <= 1'b0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_src   <= w_src_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    always_comb begin
        w_any       = req0_valid | req1_valid;
        // r_rr=1 prefers req1; a lone valid requester always wins
        w_gnt       = req1_valid & (~req0_valid | r_rr);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_src_nxt   = r_src;
        w_rr_nxt    = r_rr;
        w_grant_en  = 1'b0;
        w_load      = 1'b0;
        w_x         = '0;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;
        w_sv        = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_grant_en = w_any;
            end
            StShift: begin
                w_sv = 1'b1;
                if (r_cnt == CntLast) begin
                    w_grant_en = w_any;
                    if (!w_any) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        if (w_grant_en) begin
            w_load      = 1'b1;
            w_x         = w_gnt ? req1_data : req0_data;
            w_rdy0      = ~w_gnt;
            w_rdy1      = w_gnt;
            w_src_nxt   = w_gnt;
            w_rr_nxt    = ~w_gnt;
            w_cnt_nxt   = '0;
            w_state_nxt = StShift;
        end
    end

    // Gate with rst_n so every output is low during reset, independent of clk
    always_comb begin
        ser_valid  = rst_n & w_sv;
        ser_out    = ser_valid & ser_in;
        ser_sof    = ser_valid & (r_cnt == '0);
        ser_src    = ser_valid & r_src;
        busy       = ser_valid;
        piso_load  = rst_n & w_load;
        piso_x     = {WIDTH{rst_n}} & w_x;
        req0_ready = rst_n & w_rdy0;
        req1_ready = rst_n & w_rdy1;
    end

endmodule

// File: tb/tb_srlzr_ctrl.sv
// Scoreboard bench for srlzr_ctrl with an MSB-first PISO model on the serial side.
module tb_srlzr_ctrl;

    localparam int W = 4;

    typedef struct packed {
        logic         src;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data = '0;
    logic         req1_ready;
    logic         piso_load;
    logic [W-1:0] piso_x;
    logic         ser_in;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_sof;
    logic         ser_src;
    logic         busy;
    logic [W-1:0] sr = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vcount = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int load_cyc = -10;
    int bit_idx = 0;
    int rdy0_cnt = 0;
    int rdy1_cnt = 0;
    bit have_cur = 1'b0;
    exp_t cur;
    exp_t exp_q[$];
    logic [W-1:0] w0_q[$];
    logic [W-1:0] w1_q[$];

    srlzr_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .piso_load  (piso_load),
        .piso_x     (piso_x),
        .ser_in     (ser_in),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_sof    (ser_sof),
        .ser_src    (ser_src),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (piso_load) sr <= piso_x;
        else           sr <= {sr[W-2:0], 1'b0};
    end
    assign ser_in = sr[W-1];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requesters: hold valid/data until ready is seen, then present the next queued word
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = req0_valid && req0_ready;
            @(posedge clk);
            #1;
            if (hs) begin req0_valid = 1'b0; req0_data = '0; end
            if (!req0_valid && w0_q.size() > 0) begin
                req0_valid = 1'b1;
                req0_data  = w0_q.pop_front();
            end
        end
    end

    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (hs) begin req1_valid = 1'b0; req1_data = '0; end
            if (!req1_valid && w1_q.size() > 0) begin
                req1_valid = 1'b1;
                req1_data  = w1_q.pop_front();
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            have_cur = 1'b0;
        end else begin
            if (req0_ready) begin rdy0_cnt++; chk("rdy0_needs_valid", int'(req0_valid), 1); end
            if (req1_ready) begin rdy1_cnt++; chk("rdy1_needs_valid", int'(req1_valid), 1); end
            if (!piso_load) chk("piso_x_idle", int'(piso_x), 0);
            chk("busy_eq_valid", int'(busy), int'(ser_valid));
            if (ser_valid) begin
                if (ser_sof) begin
                    if (have_cur) chk("word_truncated", bit_idx, W);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 1, 0);
                        have_cur = 1'b0;
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        bit_idx  = 0;
                        chk("ser_src", int'(ser_src), int'(cur.src));
                        chk("load_to_sof_latency", cyc - load_cyc, 1);
                    end
                end
                if (have_cur) begin
                    chk("ser_out", int'(ser_out), int'(cur.data[W-1-bit_idx]));
                    chk("ser_sof_pos", int'(ser_sof), (bit_idx == 0) ? 1 : 0);
                    chk("ser_src_hold", int'(ser_src), int'(cur.src));
                    bit_idx++;
                    if (bit_idx == W) have_cur = 1'b0;
                end else begin
                    chk("stray_bit", 1, 0);
                end
                if (vcount == 0) first_cyc = cyc;
                last_cyc = cyc;
                vcount++;
            end else begin
                if (have_cur) begin chk("gap_mid_word", 1, 0); have_cur = 1'b0; end
                chk("idle_outputs", int'({ser_out, ser_sof, ser_src}), 0);
            end
            if (piso_load) load_cyc = cyc;
        end
    end

    task automatic req(input int who, input logic [W-1:0] d);
        if (who == 0) w0_q.push_back(d);
        else          w1_q.push_back(d);
    endtask

    task automatic expect_word(input logic s, input logic [W-1:0] d);
        exp_t e;
        e.src  = s;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic start_test();
        vcount   = 0;
        rdy0_cnt = 0;
        rdy1_cnt = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && !have_cur && w0_q.size() == 0 && w1_q.size() == 0 &&
                 !req0_valid && !req1_valid) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) chk("timeout_wait_idle", 1, 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_vcount(input int target);
        int n = 0;
        while (vcount < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("timeout_wait_vcount", 1, 0);
    endtask

    function automatic int all_outs();
        return int'({req0_ready, req1_ready, piso_load, piso_x, ser_out, ser_valid,
                     ser_sof, ser_src, busy});
    endfunction

    initial begin
        #1;
        chk("reset_outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single req0 word
        start_test();
        req(0, 4'b1011);
        expect_word(1'b0, 4'b1011);
        wait_idle();
        chk("t26_bits", vcount, 4);
        chk("t26_span", last_cyc - first_cyc + 1, 4);
        chk("t26_rdy0", rdy0_cnt, 1);
        chk("t26_rdy1", rdy1_cnt, 0);

        // Both valid from reset: req0 first, req1 back-to-back
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        start_test();
        req(0, 4'b0110);
        req(1, 4'b1001);
        expect_word(1'b0, 4'b0110);
        expect_word(1'b1, 4'b1001);
        wait_idle();
        chk("t27_bits", vcount, 8);
        chk("t27_span", last_cyc - first_cyc + 1, 8);

        // Six words with both continuously valid: strict alternation
        start_test();
        req(0, 4'b0011); req(0, 4'b0101); req(0, 4'b1100);
        req(1, 4'b1010); req(1, 4'b1110); req(1, 4'b0111);
        expect_word(1'b0, 4'b0011); expect_word(1'b1, 4'b1010);
        expect_word(1'b0, 4'b0101); expect_word(1'b1, 4'b1110);
        expect_word(1'b0, 4'b1100); expect_word(1'b1, 4'b0111);
        wait_idle();
        chk("t28_bits", vcount, 24);
        chk("t28_span", last_cyc - first_cyc + 1, 24);
        chk("t28_rdy0", rdy0_cnt, 3);
        chk("t28_rdy1", rdy1_cnt, 3);

        // req1 alone, then again after an idle gap
        start_test();
        req(1, 4'b1101);
        expect_word(1'b1, 4'b1101);
        wait_vcount(4);
        repeat (3) @(posedge clk);
        req(1, 4'b0010);
        expect_word(1'b1, 4'b0010);
        wait_idle();
        chk("t29_bits", vcount, 8);
        chk("t29_span_with_gap", last_cyc - first_cyc + 1, 12);
        chk("t29_rdy1", rdy1_cnt, 2);

        // Reset during bit 2 of a req0 word (leaves rr pointing at req1 if not reset)
        start_test();
        req(0, 4'b1110);
        expect_word(1'b0, 4'b1110);
        wait_vcount(2);
        #3 rst_n = 1'b0;
        #1 chk("t30_async_clear", all_outs(), 0);
        req(0, 4'b0101);
        req(1, 4'b1010);
        expect_word(1'b0, 4'b0101);
        expect_word(1'b1, 4'b1010);
        repeat (2) @(posedge clk);
        #2 chk("t30_reset_with_valid", all_outs(), 0);
        chk("t30_aborted_bits", vcount, 2);
        start_test();
        rst_n = 1'b1;
        wait_idle();
        chk("t30_bits", vcount, 8);
        chk("t30_span", last_cyc - first_cyc + 1, 8);
        chk("t30_rdy0", rdy0_cnt, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/srlzr_ctrl.md
SRLZR_CTRL -- requirements
Module: srlzr_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the serializer word length in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N holds a word.
REQ-005 SHALL have ports req0_data and req1_data, input, WIDTH bits each: the requester's parallel word.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 bit each: the word is accepted this cycle.
REQ-007 SHALL have port piso_load, output, 1 bit: load strobe to the shift register; low means shift.
REQ-008 SHALL have port piso_x, output, WIDTH bits: parallel word driven to the shift register.
REQ-009 SHALL have port ser_in, input, 1 bit: serial output of the shift register.
REQ-010 SHALL have port ser_out, output, 1 bit: serial data forwarded downstream.
REQ-011 SHALL have ports ser_valid, ser_sof and ser_src, output, 1 bit each: bit valid, first bit of word, and source requester (0/1).
REQ-012 SHALL have port busy, output, 1 bit: a word is being shifted.

Function
REQ-013 SHALL implement states IDLE and SHIFT, a bit counter cnt (0..WIDTH-1), a source register src and a round-robin pointer rr.
REQ-014 Handshake: a requester SHALL hold valid and data stable until it sees ready; ready SHALL be combinational and high for exactly one cycle per accepted word.
REQ-015 Grant: rr SHALL select the preferred requester. If only one requester is valid, that requester SHALL win. If both are valid, the rr requester SHALL win. After each grant, rr SHALL point to the other requester.
REQ-016 IDLE with any valid: SHALL assert piso_load=1, drive piso_x with the granted data, assert the granted reqN_ready, set src to the grant, clear cnt and go to SHIFT.
REQ-017 IDLE with no valid: piso_load=0, piso_x=0, no ready; SHALL stay in IDLE.
REQ-018 SHIFT: ser_valid=1, ser_out=ser_in, ser_sof=(cnt==0), ser_src=src and busy=1; piso_load=0 while cnt<WIDTH-1; cnt SHALL increment each cycle.
REQ-019 Last bit (cnt==WIDTH-1) with any valid: SHALL perform the REQ-016 grant/load in the same cycle and stay in SHIFT with cnt=0. This gives zero-gap back-to-back words, and the last bit SHALL still be presented on ser_out.
REQ-020 Last bit with no valid: SHALL return to IDLE; ser_valid SHALL be 0 the next cycle.
REQ-021 Outside SHIFT: ser_valid, ser_sof, ser_out, ser_src and busy SHALL be 0.
REQ-022 Each accepted word SHALL produce exactly WIDTH ser_valid cycles, starting the cycle after its load. No word SHALL be dropped or duplicated.
REQ-023 Requester valid deasserting without a ready (protocol violation) SHALL cause no grant; the controller SHALL NOT latch req data except through piso_x.

Reset
REQ-024 While rst_n=0: state=IDLE, cnt=0, src=0, rr=0 (req0 preferred); all outputs SHALL be 0 regardless of clk.
REQ-025 Reset asserted mid-word SHALL abort the word immediately with no further ser_valid. After release, the controller SHALL start from IDLE, and the aborted word SHALL NOT be replayed.

Verification
REQ-026 WIDTH=4; req0 sends 4'b1011 alone; model shift register connected -> req0_ready one cycle; then 4 cycles ser_valid=1, ser_src=0, sof on first; bits match model order; then idle.
REQ-027 req0 and req1 valid at once from reset -> req0 granted first, req1 loaded on req0's 4th bit cycle; 8 consecutive ser_valid cycles, sof on cycles 1 and 5, ser_src 0 then 1.
REQ-028 Both requesters continuously valid for 6 words -> grants alternate 0,1,0,1,0,1; ser_valid never drops; 24 bits total.
REQ-029 Single req1 word, then req1 revalid 3 cycles after last bit -> return to IDLE with ser_valid=0 gap, then a new sof with ser_src=1.
REQ-030 rst_n pulsed low on bit 2 of a word -> outputs 0 asynchronously; after release, the next grant goes to req0 if both valid.
